// File: rtl/mem_access_sched.sv
// mem_access_sched
// Shares one memory controller port among NREQ requesters. A winner is picked
// in IDLE, its command is latched, and the access is sequenced through SETUP,
// ACCESS and RECOVER before the next arbitration. Completion is signalled with
// a one-hot done pulse, and read data is returned on rdata.
//
// Build option: define MEM_SCHED_FIXED_PRIO_EN for fixed priority arbitration
// (lowest index wins, no round-robin pointer). Default is round robin.
// Timing, handshake and outputs are the same in both builds.
module mem_access_sched #(
    parameter int NREQ      = 4,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int T_SETUP   = 1,
    parameter int T_ACCESS  = 3,
    parameter int T_RECOVER = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] CNT_SETUP   = 8'(T_SETUP - 1);
    localparam logic [7:0] CNT_ACCESS  = 8'(T_ACCESS - 1);
    localparam logic [7:0] CNT_RECOVER = 8'(T_RECOVER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t        state;
    logic [7:0]    cnt;

    // Arbitration result for the current cycle.
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          found;

    // Command of the access in flight, captured with the grant.
    logic [IW-1:0] cur_idx;
    logic          cmd_we;
    logic [DW-1:0] cmd_wdata;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

`ifdef MEM_SCHED_FIXED_PRIO_EN
    // Fixed priority search: the lowest requesting index wins
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        if (int'(w) == NREQ - 1) begin
            return '0;
        end
        return w + 1'b1;
    endfunction

    // Round-robin pointer: the requester after the latest winner is searched first
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == S_IDLE && found) begin
            rr_ptr <= next_ptr(win_idx);
        end
    end

    // Rotated search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

    // Command latch: the winner's command is held for the whole access
    always_ff @(posedge clk) begin
        if (state == S_IDLE && found) begin
            cur_idx   <= win_idx;
            cmd_we    <= req_we[win_idx];
            cmd_wdata <= req_wdata[int'(win_idx)*DW +: DW];
        end
    end

    // Sequencer: phase timing plus every registered output of the block
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state    <= S_SETUP;
                        cnt      <= CNT_SETUP;
                        gnt      <= onehot(win_idx);
                        busy     <= 1'b1;
                        mem_cs   <= 1'b1;
                        mem_addr <= req_addr[int'(win_idx)*AW +: AW];
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        state     <= S_ACCESS;
                        cnt       <= CNT_ACCESS;
                        mem_we    <= cmd_we;
                        mem_wdata <= cmd_we ? cmd_wdata : '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 8'd0) begin
                        // Last strobe cycle: the read data is taken here.
                        state     <= S_RECOVER;
                        cnt       <= CNT_RECOVER;
                        mem_cs    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        done      <= onehot(cur_idx);
                        if (!cmd_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (cnt == 8'd0) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sched.sv
// tb_mem_access_sched
// Scoreboard bench for mem_access_sched: a transaction-level model predicts
// grants, completions, read data and the per-cycle memory bus, and a monitor
// compares them against what the scheduler presents.
module tb_mem_access_sched;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TS   = 1;
    localparam int TA   = 3;
    localparam int TR   = 2;
    localparam int SPAN = TS + TA + TR;
    localparam int MAXC = 4000;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               mem_cs;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    mem_access_sched #(
        .NREQ(NREQ), .AW(AW), .DW(DW),
        .T_SETUP(TS), .T_ACCESS(TA), .T_RECOVER(TR)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int   cyc;
        int   idx;
        logic we;
    } exp_t;

    exp_t          gq[$];
    exp_t          dq[$];
    bit            exp_busy [MAXC];
    bit            exp_cs   [MAXC];
    bit            exp_we   [MAXC];
    bit [AW-1:0]   exp_addr [MAXC];
    bit [DW-1:0]   exp_wdata[MAXC];
    bit [DW-1:0]   rd_hist  [MAXC];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NREQ-1:0] oh(input int k);
        return NREQ'(1) << k;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    endtask

    // Memory read data: a fresh random value every cycle, remembered per cycle.
    initial begin : rdata_drv
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = DW'($urandom);
            if (cyc < MAXC) rd_hist[cyc] = mem_rdata;
        end
    end

    // Reference model: one access at a time, each occupying SPAN cycles after
    // the grant; winner chosen by rotating priority from the last winner.
    initial begin : model
        int   ptr;
        int   free_at;
        int   w;
        int   g;
        int   k;
        exp_t keep[$];
        ptr     = 0;
        free_at = 0;
        forever begin
            @(negedge clk);
            if (cyc < MAXC - 2*SPAN) begin
                if (rst) begin
                    for (int t = cyc + 1; t <= cyc + SPAN + 1; t++) begin
                        exp_busy[t]  = 1'b0;
                        exp_cs[t]    = 1'b0;
                        exp_we[t]    = 1'b0;
                        exp_addr[t]  = '0;
                        exp_wdata[t] = '0;
                    end
                    keep = {};
                    foreach (gq[i]) if (gq[i].cyc <= cyc) keep.push_back(gq[i]);
                    gq = keep;
                    keep = {};
                    foreach (dq[i]) if (dq[i].cyc <= cyc) keep.push_back(dq[i]);
                    dq = keep;
                    ptr     = 0;
                    free_at = cyc + 1;
                end else if (cyc >= free_at && req != '0) begin
                    w = -1;
                    for (int i = 0; i < NREQ; i++) begin
`ifdef MEM_SCHED_FIXED_PRIO_EN
                        k = i;
`else
                        k = (ptr + i) % NREQ;
`endif
                        if (w < 0 && req[k]) w = k;
                    end
                    g = cyc + 1;
                    gq.push_back('{cyc: g, idx: w, we: req_we[w]});
                    dq.push_back('{cyc: g + TS + TA, idx: w, we: req_we[w]});
                    for (int t = g; t < g + SPAN; t++) begin
                        exp_busy[t] = 1'b1;
                        if (t < g + TS + TA) begin
                            exp_cs[t]   = 1'b1;
                            exp_addr[t] = req_addr[w*AW +: AW];
                        end
                        if (t >= g + TS && t < g + TS + TA) begin
                            exp_we[t]    = req_we[w];
                            exp_wdata[t] = req_we[w] ? req_wdata[w*DW +: DW] : '0;
                        end
                    end
                    free_at = g + SPAN;
                    ptr     = (w + 1) % NREQ;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents gnt or done, and
    // compares the memory bus and rdata every cycle.
    initial begin : monitor
        exp_t          t;
        logic [DW-1:0] rdata_exp;
        rdata_exp = '0;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    t = gq.pop_front();
                    chk("gnt_missing", 64'(0), 64'(oh(t.idx)));
                end
                while (dq.size() > 0 && dq[0].cyc < cyc) begin
                    t = dq.pop_front();
                    chk("done_missing", 64'(0), 64'(oh(t.idx)));
                end
                if (gnt != '0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 64'(gnt), 64'(0));
                    end else begin
                        t = gq.pop_front();
                        chk("gnt_onehot", 64'(gnt), 64'(oh(t.idx)));
                        chk("gnt_cycle", 64'(cyc), 64'(t.cyc));
                    end
                end
                if (done != '0) begin
                    if (dq.size() == 0) begin
                        chk("done_unexpected", 64'(done), 64'(0));
                    end else begin
                        t = dq.pop_front();
                        chk("done_onehot", 64'(done), 64'(oh(t.idx)));
                        chk("done_cycle", 64'(cyc), 64'(t.cyc));
                        if (!t.we) rdata_exp = rd_hist[t.cyc - 1];
                    end
                end
                chk("bus_busy_cs_we_addr_wdata_rdata",
                    64'({busy, mem_cs, mem_we, mem_addr, mem_wdata, rdata}),
                    64'({exp_busy[cyc], exp_cs[cyc], exp_we[cyc], exp_addr[cyc],
                         exp_wdata[cyc], rdata_exp}));
                if (rst) rdata_exp = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_we[k]            = we;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic wait_gnt(input int k);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt[k] && n < 60);
        chk("gnt_seen", 64'(gnt[k]), 64'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 60);
        chk("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int t = 0; t < n; t++) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (gnt[k]) begin
                    set_cmd(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                    if ($urandom_range(0, 3) != 0) req[k] = 1'b0;
                end else if (req[k]) begin
                    if ($urandom_range(0, 63) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    set_cmd(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                    req[k] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
        end
    endtask

    initial begin : watchdog
        #((MAXC - 100) * 10);
        $display("FAIL watchdog: run did not finish within %0d cycles", MAXC - 100);
        $fatal(1);
    end

    initial begin : stimulus
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from requester 1.
        set_cmd(1, 1'b1, 16'h1234, 8'hA5);
        req[1] = 1'b1;
        wait_gnt(1);
        req = '0;
        wait_idle();

        // Single read from requester 2, then a write that must not touch rdata.
        set_cmd(2, 1'b0, 16'h0040, 8'h00);
        req[2] = 1'b1;
        wait_gnt(2);
        req = '0;
        wait_idle();
        set_cmd(0, 1'b1, 16'h0777, 8'h5A);
        req[0] = 1'b1;
        wait_gnt(0);
        req = '0;
        wait_idle();

        // All four held straight after reset: rotation 0,1,2,3,0.
        pulse_rst();
        for (int k = 0; k < NREQ; k++) set_cmd(k, 1'(k % 2), AW'(16'h1000 + k), DW'(8'h10 + k));
        req = '1;
        repeat (30) tick();
        req = '0;
        wait_idle();

        // Requester 3 keeps asking; requester 0 joins during the access.
        set_cmd(3, 1'b0, 16'h0333, 8'h00);
        req[3] = 1'b1;
        wait_gnt(3);
        repeat (3) tick();
        set_cmd(0, 1'b0, 16'h0300, 8'h00);
        req[0] = 1'b1;
        wait_gnt(0);
        req = '0;
        wait_idle();

        // Reset in the middle of ACCESS, then requesters 0 and 3 together.
        set_cmd(1, 1'b1, 16'hBEEF, 8'h77);
        req[1] = 1'b1;
        wait_gnt(1);
        req = '0;
        tick();
        pulse_rst();
        set_cmd(0, 1'b1, 16'h0A0A, 8'h0A);
        set_cmd(3, 1'b1, 16'h3A3A, 8'h3A);
        req = 4'b1001;
        wait_gnt(0);
        req = '0;
        wait_idle();

        // Requester 2 pulses for one cycle while the block is busy.
        set_cmd(1, 1'b0, 16'h0101, 8'h00);
        req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        tick();
        set_cmd(2, 1'b0, 16'h0202, 8'h00);
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        wait_idle();
        repeat (4) tick();

        // Randomised traffic with withdrawals, re-requests and resets.
        rand_phase(1500);
        rst = 1'b0;
        req = '0;
        wait_idle();
        repeat (SPAN + 4) tick();
        chk("queues_drained", 64'(gq.size() + dq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
